// File: rtl/fat32_sector_write_scheduler.sv
// Maps sequential file sectors of a contiguous FAT32 file to LBAs and serialises data and
// directory-entry writes onto a single SD sector-write engine, one write in flight at a time.
module fat32_sector_write_scheduler #(
   parameter int unsigned SECTOR_BYTES = 512,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_part_base,
   input  logic [15:0]       cfg_reserved_sectors,
   input  logic [ADDR_W-1:0] cfg_fat_length,
   input  logic [7:0]        cfg_number_of_fat,
   input  logic [7:0]        cfg_sectors_per_cluster,
   input  logic [ADDR_W-1:0] cfg_start_cluster,
   input  logic [ADDR_W-1:0] cfg_root_cluster,
   input  logic [ADDR_W-1:0] cfg_max_cluster,
   input  logic              data_valid,
   output logic              data_accept,
   input  logic              finish_req,
   output logic              finish_accept,
   output logic              sd_wr_req,
   output logic [ADDR_W-1:0] sd_wr_addr,
   output logic              sd_wr_src,
   input  logic              sd_wr_ack,
   input  logic              sd_wr_done,
   output logic [ADDR_W-1:0] sector_count,
   output logic [ADDR_W-1:0] cur_cluster,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // Addresses are counted in sectors; the byte size only has to be a sane nonzero value.
   if (SECTOR_BYTES == 0) begin : g_sector_bytes_check
      $error("SECTOR_BYTES must be nonzero");
   end

   typedef enum logic [2:0] {
      StIdle, StCalc, StReady, StIssue, StWait, StDirIssue, StDirWait, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] part_q, fat_len_q, start_clu_q, root_q, max_q;
   logic [15:0]       resv_q;
   logic [7:0]        nfat_q, spc_q, sec_q;
   logic [ADDR_W-1:0] first_data_q, addr_q, count_q, cluster_q;
   logic              src_q, error_q, data_acc_q, fin_acc_q, done_pend_q;

   logic [ADDR_W-1:0] spc_ext, data_lba, dir_lba, next_cluster;
   logic              sec_wrap, done_seen;

   always_comb begin
      spc_ext      = ADDR_W'(spc_q);
      data_lba     = first_data_q + (cluster_q - ADDR_W'(2)) * spc_ext + ADDR_W'(sec_q);
      dir_lba      = first_data_q + (root_q - ADDR_W'(2)) * spc_ext;
      sec_wrap     = (sec_q == spc_q - 8'd1);
      next_cluster = sec_wrap ? cluster_q + ADDR_W'(1) : cluster_q;
      // A done that arrived together with the ack is replayed from done_pend_q.
      done_seen    = sd_wr_done | done_pend_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (start) state_d = StCalc;
         StCalc:     state_d = StReady;
         StReady: begin
            if (data_valid)      state_d = StIssue;
            else if (finish_req) state_d = StDirIssue;
         end
         StIssue:    if (sd_wr_ack) state_d = StWait;
         StWait: begin
            if (done_seen) state_d = (next_cluster > max_q) ? StDone : StReady;
         end
         StDirIssue: if (sd_wr_ack) state_d = StDirWait;
         StDirWait:  if (done_seen) state_d = StDone;
         StDone:     state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         part_q       <= '0;
         fat_len_q    <= '0;
         start_clu_q  <= '0;
         root_q       <= '0;
         max_q        <= '0;
         resv_q       <= '0;
         nfat_q       <= '0;
         spc_q        <= '0;
         sec_q        <= '0;
         first_data_q <= '0;
         addr_q       <= '0;
         count_q      <= '0;
         cluster_q    <= '0;
         src_q        <= 1'b0;
         error_q      <= 1'b0;
         data_acc_q   <= 1'b0;
         fin_acc_q    <= 1'b0;
         done_pend_q  <= 1'b0;
      end else begin
         data_acc_q <= (state_q == StIssue) && sd_wr_ack;
         fin_acc_q  <= (state_q == StDirIssue) && sd_wr_ack;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  part_q      <= cfg_part_base;
                  resv_q      <= cfg_reserved_sectors;
                  fat_len_q   <= cfg_fat_length;
                  nfat_q      <= cfg_number_of_fat;
                  spc_q       <= (cfg_sectors_per_cluster == 8'd0) ? 8'd1
                                                                    : cfg_sectors_per_cluster;
                  start_clu_q <= cfg_start_cluster;
                  root_q      <= cfg_root_cluster;
                  max_q       <= cfg_max_cluster;
                  error_q     <= 1'b0;
                  count_q     <= '0;
               end
            end
            StCalc: begin
               first_data_q <= part_q + ADDR_W'(resv_q) + fat_len_q * ADDR_W'(nfat_q);
               cluster_q    <= start_clu_q;
               sec_q        <= '0;
            end
            StReady: begin
               if (data_valid) begin
                  addr_q <= data_lba;
                  src_q  <= 1'b0;
               end else if (finish_req) begin
                  addr_q <= dir_lba;
                  src_q  <= 1'b1;
               end
            end
            StIssue, StDirIssue: done_pend_q <= sd_wr_ack & sd_wr_done;
            StWait: begin
               if (done_seen) begin
                  done_pend_q <= 1'b0;
                  count_q     <= count_q + ADDR_W'(1);
                  cluster_q   <= next_cluster;
                  sec_q       <= sec_wrap ? 8'd0 : sec_q + 8'd1;
                  if (next_cluster > max_q) error_q <= 1'b1;
               end
            end
            StDirWait: if (done_seen) done_pend_q <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      sd_wr_req     = (state_q == StIssue) || (state_q == StDirIssue);
      sd_wr_addr    = addr_q;
      sd_wr_src     = src_q;
      data_accept   = data_acc_q;
      finish_accept = fin_acc_q;
      sector_count  = count_q;
      cur_cluster   = cluster_q;
      busy          = (state_q != StIdle);
      done          = (state_q == StDone);
      error         = error_q;
   end

endmodule

// File: tb/tb_fat32_sector_write_scheduler.sv
// Bench for the FAT32 sector write scheduler: directed geometry cases plus randomised files,
// checked against an arithmetic model of the file layout and a behavioural SD engine.
module tb_fat32_sector_write_scheduler;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n, start, data_valid, finish_req, sd_wr_ack, sd_wr_done;
   logic [31:0] cfg_part_base, cfg_fat_length, cfg_start_cluster, cfg_root_cluster;
   logic [31:0] cfg_max_cluster;
   logic [15:0] cfg_reserved_sectors;
   logic [7:0]  cfg_number_of_fat, cfg_sectors_per_cluster;
   logic        data_accept, finish_accept, sd_wr_req, sd_wr_src, busy, done, error;
   logic [31:0] sd_wr_addr, sector_count, cur_cluster;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 sys_clk = ~sys_clk;

   fat32_sector_write_scheduler #(.SECTOR_BYTES(512), .ADDR_W(32)) dut (
      .sys_clk                 (sys_clk),
      .sys_rst_n               (sys_rst_n),
      .start                   (start),
      .cfg_part_base           (cfg_part_base),
      .cfg_reserved_sectors    (cfg_reserved_sectors),
      .cfg_fat_length          (cfg_fat_length),
      .cfg_number_of_fat       (cfg_number_of_fat),
      .cfg_sectors_per_cluster (cfg_sectors_per_cluster),
      .cfg_start_cluster       (cfg_start_cluster),
      .cfg_root_cluster        (cfg_root_cluster),
      .cfg_max_cluster         (cfg_max_cluster),
      .data_valid              (data_valid),
      .data_accept             (data_accept),
      .finish_req              (finish_req),
      .finish_accept           (finish_accept),
      .sd_wr_req               (sd_wr_req),
      .sd_wr_addr              (sd_wr_addr),
      .sd_wr_src               (sd_wr_src),
      .sd_wr_ack               (sd_wr_ack),
      .sd_wr_done              (sd_wr_done),
      .sector_count            (sector_count),
      .cur_cluster             (cur_cluster),
      .busy                    (busy),
      .done                    (done),
      .error                   (error)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   // Plays the SD engine for one write: wait for the request, hold off the ack, then finish.
   task automatic do_write(input string tag, input logic [31:0] exp_addr, input bit is_dir,
                           input int dly, input bit coin);
      int guard = 0;
      while (!sd_wr_req && guard < 20) begin
         tick();
         guard++;
      end
      check_eq({tag, "_req"}, {31'd0, sd_wr_req}, 32'd1);
      check_eq({tag, "_addr"}, sd_wr_addr, exp_addr);
      check_eq({tag, "_src"}, {31'd0, sd_wr_src}, {31'd0, is_dir});
      for (int i = 0; i < dly; i++) begin
         tick();
         check_eq({tag, "_hold_req"}, {31'd0, sd_wr_req}, 32'd1);
         check_eq({tag, "_hold_addr"}, sd_wr_addr, exp_addr);
      end
      sd_wr_ack  = 1'b1;
      sd_wr_done = coin;
      tick();
      sd_wr_ack  = 1'b0;
      sd_wr_done = 1'b0;
      check_eq({tag, "_req_drop"}, {31'd0, sd_wr_req}, 32'd0);
      check_eq({tag, "_accept"}, {31'd0, is_dir ? finish_accept : data_accept}, 32'd1);
      if (is_dir) finish_req = 1'b0;
      else        data_valid = 1'b0;
      if (!coin) begin
         repeat ($urandom_range(0, 2)) tick();
         sd_wr_done = 1'b1;
         tick();
         sd_wr_done = 1'b0;
      end else begin
         tick();
      end
      check_eq({tag, "_accept_end"}, {31'd0, is_dir ? finish_accept : data_accept}, 32'd0);
   endtask

   task automatic do_start(input logic [31:0] part, input logic [15:0] res,
                           input logic [31:0] fl, input logic [7:0] nf, input logic [7:0] spc,
                           input logic [31:0] startc, input logic [31:0] root,
                           input logic [31:0] maxc);
      cfg_part_base           = part;
      cfg_reserved_sectors    = res;
      cfg_fat_length          = fl;
      cfg_number_of_fat       = nf;
      cfg_sectors_per_cluster = spc;
      cfg_start_cluster       = startc;
      cfg_root_cluster        = root;
      cfg_max_cluster         = maxc;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_part_base = $urandom;
      check_eq("start_busy", {31'd0, busy}, 32'd1);
      check_eq("start_count", sector_count, 32'd0);
      check_eq("start_error", {31'd0, error}, 32'd0);
   endtask

   task automatic run_file(input logic [31:0] part, input logic [15:0] res,
                           input logic [31:0] fl, input logic [7:0] nf, input logic [7:0] spc,
                           input logic [31:0] startc, input logic [31:0] root,
                           input logic [31:0] maxc, input int nsec, input int dly,
                           input bit coin, input bit prio);
      logic [31:0] fd, spc_e, clu;
      fd    = part + {16'd0, res} + fl * {24'd0, nf};
      spc_e = (spc == 8'd0) ? 32'd1 : {24'd0, spc};
      do_start(part, res, fl, nf, spc, startc, root, maxc);
      for (int n = 0; n < nsec; n++) begin
         data_valid = 1'b1;
         if (prio && n == nsec - 1) finish_req = 1'b1;
         // Contiguous file: sector n sits n sectors past the start cluster's first sector.
         do_write("data", fd + (startc - 32'd2) * spc_e + 32'(n), 1'b0, dly, coin);
         clu = startc + 32'(n + 1) / spc_e;
         check_eq("count", sector_count, 32'(n + 1));
         check_eq("cluster", cur_cluster, clu);
         if (clu > maxc) begin
            check_eq("ovf_error", {31'd0, error}, 32'd1);
            check_eq("ovf_done", {31'd0, done}, 32'd1);
            tick();
            check_eq("ovf_idle", {31'd0, busy}, 32'd0);
            data_valid = 1'b1;
            repeat (3) tick();
            check_eq("ovf_no_req", {31'd0, sd_wr_req}, 32'd0);
            data_valid = 1'b0;
            finish_req = 1'b0;
            return;
         end
         check_eq("no_error", {31'd0, error}, 32'd0);
      end
      finish_req = 1'b1;
      do_write("dir", fd + (root - 32'd2) * spc_e, 1'b1, dly, coin);
      check_eq("dir_done", {31'd0, done}, 32'd1);
      check_eq("dir_count", sector_count, 32'(nsec));
      tick();
      check_eq("end_busy", {31'd0, busy}, 32'd0);
      check_eq("end_done", {31'd0, done}, 32'd0);
      check_eq("end_cluster", cur_cluster, startc + 32'(nsec) / spc_e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] s, m;
      sys_rst_n  = 1'b0;
      start      = 1'b0;
      data_valid = 1'b0;
      finish_req = 1'b0;
      sd_wr_ack  = 1'b0;
      sd_wr_done = 1'b0;
      cfg_part_base = '0; cfg_reserved_sectors = '0; cfg_fat_length = '0;
      cfg_number_of_fat = '0; cfg_sectors_per_cluster = '0; cfg_start_cluster = '0;
      cfg_root_cluster = '0; cfg_max_cluster = '0;
      tick();
      tick();
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_req", {31'd0, sd_wr_req}, 32'd0);
      check_eq("rst_count", sector_count, 32'd0);
      check_eq("rst_cluster", cur_cluster, 32'd0);
      check_eq("rst_flags", {28'd0, error, done, data_accept, finish_accept}, 32'd0);
      sys_rst_n = 1'b1;
      tick();

      // Geometry, cluster rollover, priority, overflow, handshake timing, SPC of zero.
      run_file(32'd8192, 16'd32, 32'd1000, 8'd2, 8'd8, 32'd2, 32'd2, 32'd100, 3, 0, 1'b0, 1'b0);
      run_file(32'd8192, 16'd32, 32'd1000, 8'd2, 8'd4, 32'd5, 32'd2, 32'd100, 9, 1, 1'b0, 1'b0);
      run_file(32'd8192, 16'd32, 32'd1000, 8'd2, 8'd8, 32'd2, 32'd2, 32'd100, 1, 0, 1'b0, 1'b1);
      run_file(32'd8192, 16'd32, 32'd1000, 8'd2, 8'd1, 32'd3, 32'd2, 32'd3, 3, 0, 1'b0, 1'b0);
      run_file(32'd8192, 16'd32, 32'd1000, 8'd2, 8'd8, 32'd2, 32'd9, 32'd100, 2, 5, 1'b0, 1'b0);
      run_file(32'd8192, 16'd32, 32'd1000, 8'd2, 8'd8, 32'd2, 32'd9, 32'd100, 3, 2, 1'b1, 1'b0);
      run_file(32'd100, 16'd6, 32'd50, 8'd1, 8'd0, 32'd4, 32'd2, 32'd5, 3, 0, 1'b0, 1'b0);

      // Reset while a data write is being requested.
      do_start(32'd8192, 16'd32, 32'd1000, 8'd2, 8'd8, 32'd2, 32'd2, 32'd100);
      data_valid = 1'b1;
      repeat (3) tick();
      check_eq("mid_req", {31'd0, sd_wr_req}, 32'd1);
      sys_rst_n = 1'b0;
      tick();
      check_eq("mid_rst_req", {31'd0, sd_wr_req}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_eq("mid_rst_count", sector_count, 32'd0);
      sys_rst_n  = 1'b1;
      data_valid = 1'b0;
      tick();

      for (int r = 0; r < 25; r++) begin
         s = 32'($urandom_range(2, 1000));
         m = s + 32'($urandom_range(0, 3));
         run_file($urandom, 16'($urandom_range(0, 65535)), $urandom,
                  8'($urandom_range(1, 4)), 8'($urandom_range(0, 10)), s,
                  32'($urandom_range(2, 1000)), m, $urandom_range(1, 10),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fat32_sector_write_scheduler.md
Name: fat32_sector_write_scheduler

Overview:
Sequences sector-level writes of one contiguously allocated FAT32 file onto the shared SD sector-write engine. It computes the first data sector from the BPB fields and maps each full 512-byte buffer to an LBA via cluster/sector counters. It arbitrates between two requesters, the data-sector buffer and the directory-entry updater, and guarantees only one write is in flight. It sits between the write buffer/directory builder and the SD write controller.

Parameters:
SECTOR_BYTES, 512, sector size (documentation only; all addresses in sectors)
ADDR_W, 32, LBA/cluster/count width

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset, sampled on rising sys_clk
start  in  1  one-cycle pulse; latches all cfg_* inputs; ignored unless IDLE
cfg_part_base  in  32  partition start LBA
cfg_reserved_sectors  in  16  BPB reserved sectors
cfg_fat_length  in  32  sectors per FAT
cfg_number_of_fat  in  8  FAT copies
cfg_sectors_per_cluster  in  8  SPC; 0 treated as 1
cfg_start_cluster  in  32  first file cluster (>=2)
cfg_root_cluster  in  32  root directory cluster
cfg_max_cluster  in  32  last legal cluster number
data_valid  in  1  buffer holds a full sector; held until data_accept
data_accept  out  1  one-cycle pulse when SD engine acks a data write
finish_req  in  1  level; directory-entry sector ready, file closing
finish_accept  out  1  one-cycle pulse when SD engine acks directory write
sd_wr_req  out  1  write request, held until sd_wr_ack
sd_wr_addr  out  32  target LBA, stable while sd_wr_req=1
sd_wr_src  out  1  0=data buffer, 1=directory buffer (steers SD data mux)
sd_wr_ack  in  1  one-cycle accept pulse from SD engine
sd_wr_done  in  1  one-cycle completion pulse from SD engine
sector_count  out  32  data sectors completed since start
cur_cluster  out  32  cluster of next data sector
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on leaving DONE
error  out  1  sticky cluster overflow; cleared by start or reset

Behaviour:
- Reset (sync, sys_rst_n=0 at edge): state IDLE, every output 0, counters 0, sd_wr_req drops immediately even mid-handshake. No recovery of an in-flight SD write.
- States: IDLE, CALC, READY, ISSUE, WAIT, DIR_ISSUE, DIR_WAIT, DONE.
- IDLE: on start, latch cfg; clear error, sector_count; go CALC.
- CALC, 1 cycle: first_data = part_base + reserved + fat_length*number_of_fat, modulo 2^32. Register it. cur_cluster=start_cluster, sec_in_clu=0. Go READY.
- Data LBA = first_data + (cur_cluster-2)*SPC + sec_in_clu. Dir LBA = first_data + (root_cluster-2)*SPC. Both are 32-bit wrap. Both are registered before use: sd_wr_addr is valid the same cycle sd_wr_req rises.
- READY: data_valid has priority over finish_req (data pending must drain before close). data_valid -> ISSUE. Else finish_req -> DIR_ISSUE. Else stay.
- ISSUE: sd_wr_req=1, sd_wr_src=0. On sd_wr_ack, drop req the next cycle, pulse data_accept that same cycle, go WAIT.
- WAIT: on sd_wr_done, sector_count+1. If sec_in_clu==SPC-1: sec_in_clu=0, cur_cluster+1. Else sec_in_clu+1. If the new cur_cluster > max_cluster: set error, go DONE. Else go READY.
- DIR_ISSUE/DIR_WAIT: same as above with sd_wr_src=1 and finish_accept pulsed on ack. On done go DONE. Counters unchanged.
- DONE: 1 cycle, done=1, then IDLE. cur_cluster and sector_count hold until next start.
- sd_wr_ack and sd_wr_done arriving in the same cycle: ack processed; done consumed in the next state (WAIT must see it). Implementation registers done if it coincides with ack.
- sd_wr_ack/done outside ISSUE/WAIT states are ignored.
- start while busy is ignored. data_valid/finish_req in IDLE are ignored.

Test Plan:
- Geometry: part_base=8192, reserved=32, fat_length=1000, fats=2, SPC=8, start_cluster=2, root=2, max=100. 3 data sectors -> LBAs 10224, 10225, 10226; sector_count=3; data_accept pulsed 3 times.
- Cluster rollover: SPC=4, start_cluster=5, 9 sectors -> cur_cluster 5,5,5,5,6,6,6,6,7. First LBA = first_data+12. Final cur_cluster=7.
- Priority: data_valid and finish_req rise same cycle -> data write first (sd_wr_src=0), then directory write (sd_wr_src=1, addr=first_data), then done pulse, busy=0.
- Overflow: max_cluster=3, start_cluster=3, SPC=1 -> after first done, error=1, done pulse. Further data_valid is not accepted.
- Handshake timing: delay sd_wr_ack 5 cycles -> sd_wr_req and sd_wr_addr stable throughout. ack and done in the same cycle -> exactly one increment.
- Reset mid-write: assert sys_rst_n=0 during ISSUE -> next edge sd_wr_req=0, busy=0, sector_count=0, state IDLE.
